sprite_drawer: RTL and testbench

SPRITE_DRAWER -- requirements
Module: sprite_drawer

---
 rtl/sprite_drawer_pkg.sv | 19 +
 rtl/sprite_drawer_square_scanner.sv | 59 +++++
 rtl/sprite_drawer.sv | 180 ++++++++++++++++++
 tb/tb_sprite_drawer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_drawer_pkg.sv
// Shared screen geometry and pixel types
// for the sprite drawing slice.
package sprite_drawer_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int PLAYER_WIDTH = 3;

    typedef logic [7:0] px_x_t;
    typedef logic [6:0] px_y_t;
    typedef logic [2:0] colour_t;

    typedef struct packed {
        px_x_t      x;
        px_y_t      y;
        logic [2:0] w;
    } box_t;

endpackage

// File: rtl/sprite_drawer_square_scanner.sv
// Row-major walker over a w x w square,
// with off-screen pixels flagged invalid.
module square_scanner
    import sprite_drawer_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  px_x_t      org_x,
    input  px_y_t      org_y,
    input  logic [2:0] width,
    input  logic [8:0] lim_x,
    input  logic [7:0] lim_y,
    output logic [2:0] off_x,
    output logic [2:0] off_y,
    output logic       active,
    output logic       pixel_valid,
    output logic       last
);

    logic [2:0] w_q;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    // Offset counters: x fastest, stop after the last row
    always_ff @(posedge clk) begin
        if (!resetn) begin
            off_x  <= '0;
            off_y  <= '0;
            w_q    <= '0;
            active <= 1'b0;
        end else if (start) begin
            off_x  <= '0;
            off_y  <= '0;
            w_q    <= width;
            active <= (width != 3'd0);
        end else if (active) begin
            if (off_x == w_q - 3'd1) begin
                off_x <= '0;
                if (off_y == w_q - 3'd1)
                    active <= 1'b0;
                else
                    off_y <= off_y + 3'd1;
            end else begin
                off_x <= off_x + 3'd1;
            end
        end
    end

    assign sum_x = {1'b0, org_x} + {6'b0, off_x};
    assign sum_y = {1'b0, org_y} + {5'b0, off_y};

    assign pixel_valid = active && (sum_x < lim_x)
                         && (sum_y < lim_y);

    assign last = active && (off_x == w_q - 3'd1)
                  && (off_y == w_q - 3'd1);

endmodule

// File: rtl/sprite_drawer.sv
// Erase/redraw of one square sprite and
// full-screen clear, one pixel per cycle.
module sprite_drawer
    import sprite_drawer_pkg::*;
#(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int SCREEN_W = sprite_drawer_pkg::SCREEN_W,
    parameter int SCREEN_H = sprite_drawer_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       move,
    input  logic       clear,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [2:0] obj_width,
    input  logic [2:0] obj_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ERASE = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] state, nxt;
    box_t       cur_q, old_q;
    colour_t    col_q;
    logic       old_valid;
    logic       pend_move, pend_clear;
    logic [7:0] clr_x;
    logic [6:0] clr_y;
    logic       clr_last;

    logic       sc_start, sc_active;
    logic       sc_valid, sc_last, sc_end;
    logic [2:0] sc_w, off_x, off_y;
    px_x_t      sc_ox, px_x;
    px_y_t      sc_oy, px_y;

    assign clr_last = (clr_x == 8'(SCREEN_W - 1))
                      && (clr_y == 7'(SCREEN_H - 1));
    assign sc_end   = !sc_active || sc_last;

    // Next-state selection; clear has priority
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:
                if (clear || pend_clear)
                    nxt = S_CLEAR;
                else if (move || pend_move)
                    nxt = S_LOAD;
            S_LOAD:
                nxt = old_valid ? S_ERASE : S_DRAW;
            S_ERASE: if (sc_end) nxt = S_DRAW;
            S_DRAW:  if (sc_end) nxt = S_DONE;
            S_CLEAR: if (clr_last) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Scanner is restarted on entry to ERASE/DRAW
    always_comb begin
        sc_start = (state == S_LOAD)
                   || (state == S_ERASE && sc_end);
        if (state == S_LOAD)
            sc_w = old_valid ? old_q.w : obj_width;
        else
            sc_w = cur_q.w;
        sc_ox = (state == S_ERASE) ? old_q.x : cur_q.x;
        sc_oy = (state == S_ERASE) ? old_q.y : cur_q.y;
    end

    assign px_x = sc_ox + {5'b0, off_x};
    assign px_y = sc_oy + {4'b0, off_y};

    square_scanner u_scan (
        .clk         (clk),
        .resetn      (resetn),
        .start       (sc_start),
        .org_x       (sc_ox),
        .org_y       (sc_oy),
        .width       (sc_w),
        .lim_x       (9'(SCREEN_W)),
        .lim_y       (8'(SCREEN_H)),
        .off_x       (off_x),
        .off_y       (off_y),
        .active      (sc_active),
        .pixel_valid (sc_valid),
        .last        (sc_last)
    );

    // FSM state, position registers, pending requests
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cur_q      <= '0;
            old_q      <= '0;
            col_q      <= '0;
            old_valid  <= 1'b0;
            pend_move  <= 1'b0;
            pend_clear <= 1'b0;
            clr_x      <= '0;
            clr_y      <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && nxt == S_LOAD)
                pend_move <= 1'b0;
            else
                pend_move <= pend_move | move;
            if (state == S_IDLE && nxt == S_CLEAR)
                pend_clear <= 1'b0;
            else
                pend_clear <= pend_clear | clear;
            if (state == S_LOAD) begin
                cur_q <= '{obj_x, obj_y, obj_width};
                col_q <= obj_colour;
            end
            if (state == S_DRAW && sc_end) begin
                old_q     <= cur_q;
                old_valid <= 1'b1;
            end
            if (state == S_CLEAR && clr_last)
                old_valid <= 1'b0;
            if (state != S_CLEAR) begin
                clr_x <= '0;
                clr_y <= '0;
            end else if (clr_x == 8'(SCREEN_W - 1)) begin
                clr_x <= '0;
                clr_y <= clr_y + 7'd1;
            end else begin
                clr_x <= clr_x + 8'd1;
            end
        end
    end

    // Registered pixel and status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (nxt != S_IDLE);
            done <= (state == S_DONE);
            plot <= 1'b0;
            case (state)
                S_ERASE, S_DRAW: begin
                    if (sc_active) begin
                        vga_x <= px_x;
                        vga_y <= px_y;
                        vga_colour <= (state == S_ERASE)
                                      ? BG_COLOUR : col_q;
                        plot <= sc_valid;
                    end
                end
                S_CLEAR: begin
                    vga_x      <= clr_x;
                    vga_y      <= clr_y;
                    vga_colour <= BG_COLOUR;
                    plot       <= 1'b1;
                end
                default: plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_drawer.sv
// Scoreboard bench for sprite_drawer: expected
// pixels/done pulses queued, monitor compares.
module tb_sprite_drawer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       move = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] obj_x = '0;
    logic [6:0] obj_y = '0;
    logic [2:0] obj_width = '0;
    logic [2:0] obj_colour = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    typedef struct {
        logic       dn;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int dn_exp = 0;

    sprite_drawer dut (
        .clk        (clk),
        .resetn     (resetn),
        .move       (move),
        .clear      (clear),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_width  (obj_width),
        .obj_colour (obj_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic push_px(input int x, input int y,
                           input int c);
        exp_t e;
        e.dn = 1'b0;
        e.x = 8'(x);
        e.y = 7'(y);
        e.c = 3'(c);
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.dn = 1'b1;
        e.x = '0;
        e.y = '0;
        e.c = '0;
        q.push_back(e);
        dn_exp++;
    endtask

    // Square with off-screen pixels dropped
    task automatic push_sq(input int ox, input int oy,
                           input int w, input int c);
        for (int j = 0; j < w; j++)
            for (int i = 0; i < w; i++)
                if (ox + i < 160 && oy + j < 120)
                    push_px(ox + i, oy + j, c);
    endtask

    task automatic do_move(input int x, input int y,
                           input int w, input int c);
        @(negedge clk);
        obj_x = 8'(x);
        obj_y = 7'(y);
        obj_width = 3'(w);
        obj_colour = 3'(c);
        move = 1'b1;
        @(negedge clk);
        move = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done < dn_exp; i++)
            @(negedge clk);
        @(negedge clk);
        chk("done_count", n_done, dn_exp);
    endtask

    task automatic wait_plot(input int budget);
        for (int i = 0; i < budget && !plot; i++)
            @(negedge clk);
        chk("plot_seen", int'(plot), 1);
    endtask

    // Monitor: every plot or done must match the queue head
    always @(negedge clk) begin
        if (plot || done) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected: plot=%0d done=%0d x=%0d y=%0d",
                         plot, done, vga_x, vga_y);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.dn != done) begin
                    n_fail++;
                    $display("FAIL kind: done=%0d expected %0d (x=%0d y=%0d)",
                             done, e.dn, vga_x, vga_y);
                end else if (!e.dn && (vga_x != e.x
                             || vga_y != e.y
                             || vga_colour != e.c)) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour,
                             e.x, e.y, e.c);
                end
            end
            if (done) n_done++;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        resetn = 1'b1;

        // First draw: no erase
        push_sq(80, 115, 3, 7);
        push_done();
        do_move(80, 115, 3, 7);
        chk("busy_in_op", int'(busy), 1);
        wait_done(100);

        // Move right: erase then redraw, latency 2
        push_sq(80, 115, 3, 0);
        push_sq(81, 115, 3, 7);
        push_done();
        do_move(81, 115, 3, 7);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat_plot", int'(plot), 1);
        chk("lat_x", int'(vga_x), 80);
        chk("lat_y", int'(vga_y), 115);
        wait_done(100);

        // Corner clipping: 4 of 9 pixels written
        push_sq(81, 115, 3, 0);
        push_sq(158, 118, 3, 5);
        push_done();
        do_move(158, 118, 3, 5);
        wait_done(100);

        // Full clear, then move draws without erase
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                push_px(x, y, 0);
        push_done();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_done(20000);
        push_sq(10, 20, 2, 3);
        push_done();
        do_move(10, 20, 2, 3);
        wait_done(100);

        // Width 0: erase old only, still done
        push_sq(10, 20, 2, 0);
        push_done();
        do_move(30, 40, 0, 4);
        wait_done(100);

        // Three moves during DRAW collapse to one
        push_sq(50, 50, 3, 6);
        push_done();
        push_sq(50, 50, 3, 0);
        push_sq(50, 50, 3, 6);
        push_done();
        do_move(50, 50, 3, 6);
        wait_plot(50);
        repeat (3) begin
            move = 1'b1;
            @(negedge clk);
            move = 1'b0;
            @(negedge clk);
        end
        wait_done(200);
        repeat (30) @(negedge clk);
        chk("no_extra_done", n_done, dn_exp);
        chk("idle_busy", int'(busy), 0);

        // Reset in ERASE aborts
        push_px(50, 50, 0);
        do_move(60, 60, 2, 1);
        wait_plot(50);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", n_done, dn_exp);

        // After reset the move skips erase
        push_sq(70, 70, 1, 2);
        push_done();
        do_move(70, 70, 1, 2);
        wait_done(100);
        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
